// File: rtl/rsa_word_loader_pkg.sv
// Shared types and constants for the word-serial loader in front of the rsa_mont core.
package rsa_word_loader_pkg;

  localparam int unsigned DefaultWidth = 2048;
  localparam int unsigned DefaultWord  = 32;

  localparam logic [2:0] StLoadXEnc = 3'd0;
  localparam logic [2:0] StLoadEEnc = 3'd1;
  localparam logic [2:0] StLoadNEnc = 3'd2;
  localparam logic [2:0] StStartEnc = 3'd3;
  localparam logic [2:0] StArmEnc   = 3'd4;
  localparam logic [2:0] StWaitEnc  = 3'd5;
  localparam logic [2:0] StDrainEnc = 3'd6;

  typedef enum logic [2:0] {
    StLoadX = StLoadXEnc,
    StLoadE = StLoadEEnc,
    StLoadN = StLoadNEnc,
    StStart = StStartEnc,
    StArm   = StArmEnc,
    StWait  = StWaitEnc,
    StDrain = StDrainEnc
  } state_e;

  // A single-word operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/rsa_word_shreg.sv
// NW x WORD register with word-indexed write and a full-width parallel load.
module rsa_word_shreg
  import rsa_word_loader_pkg::*;
#(
  parameter int unsigned NW   = 64,
  parameter int unsigned WORD = DefaultWord,
  parameter int unsigned CW   = cnt_width(NW)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [CW-1:0]        wr_idx_i,
  input  logic [WORD-1:0]      wr_data_i,
  input  logic                 ld_en_i,
  input  logic [NW*WORD-1:0]   ld_data_i,
  output logic [NW*WORD-1:0]   q_o
);

  logic [NW*WORD-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_en_i) begin
      q_d = ld_data_i;
    end else if (wr_en_i) begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (wr_idx_i == CW'(k)) q_d[k*WORD +: WORD] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/rsa_word_loader.sv
// Loads X/E/N word-serially, runs one rsa_mont go/done cycle, streams the result back out.
module rsa_word_loader
  import rsa_word_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned WORD  = DefaultWord
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             busy,
  output logic             go,
  output logic [WIDTH-1:0] message_in,
  output logic [WIDTH-1:0] exponent,
  output logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] cypher,
  input  logic             done
);

  localparam int unsigned NW = WIDTH / WORD;
  localparam int unsigned CW = cnt_width(NW);

  if (WIDTH % WORD != 0) begin : g_width_check
    $error("WIDTH must be a multiple of WORD");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          go_q;
  logic          x_we, e_we, n_we, res_ld;
  logic          cnt_last;
  logic [WIDTH-1:0] res;

  assign cnt_last  = (cnt_q == CW'(NW - 1));
  assign in_ready  = state_q inside {StLoadX, StLoadE, StLoadN};
  assign out_valid = (state_q == StDrain);
  assign out_last  = out_valid & cnt_last;
  assign busy      = busy_q;
  assign go        = go_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    x_we    = 1'b0;
    e_we    = 1'b0;
    n_we    = 1'b0;
    res_ld  = 1'b0;
    unique case (state_q)
      StLoadX, StLoadE, StLoadN: begin
        if (in_valid) begin
          x_we = (state_q == StLoadX);
          e_we = (state_q == StLoadE);
          n_we = (state_q == StLoadN);
          if (state_q == StLoadX) busy_d = 1'b1;
          if (cnt_last) begin
            cnt_d = '0;
            unique case (state_q)
              StLoadX: state_d = StLoadE;
              StLoadE: state_d = StLoadN;
              default: state_d = StStart;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStart: state_d = StArm;
      // A done level left over from the previous job must fall before we trust it.
      StArm:   if (!done) state_d = StWait;
      StWait: begin
        if (done) begin
          res_ld  = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = StLoadX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StLoadX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoadX;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      go_q    <= (state_d == StStart);
    end
  end

  rsa_word_shreg #(.NW(NW), .WORD(WORD), .CW(CW)) u_x_reg (
    .clk_i(clk), .rst_i(rst), .wr_en_i(x_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .ld_en_i(1'b0), .ld_data_i('0), .q_o(message_in)
  );

  rsa_word_shreg #(.NW(NW), .WORD(WORD), .CW(CW)) u_e_reg (
    .clk_i(clk), .rst_i(rst), .wr_en_i(e_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .ld_en_i(1'b0), .ld_data_i('0), .q_o(exponent)
  );

  rsa_word_shreg #(.NW(NW), .WORD(WORD), .CW(CW)) u_n_reg (
    .clk_i(clk), .rst_i(rst), .wr_en_i(n_we), .wr_idx_i(cnt_q), .wr_data_i(in_data),
    .ld_en_i(1'b0), .ld_data_i('0), .q_o(modulus)
  );

  rsa_word_shreg #(.NW(NW), .WORD(WORD), .CW(CW)) u_res_reg (
    .clk_i(clk), .rst_i(rst), .wr_en_i(1'b0), .wr_idx_i('0), .wr_data_i('0),
    .ld_en_i(res_ld), .ld_data_i(cypher), .q_o(res)
  );

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      if (cnt_q == CW'(k)) out_data = res[k*WORD +: WORD];
    end
  end

endmodule

// File: tb/tb_rsa_word_loader.sv
// Scoreboard bench for rsa_word_loader with a behavioural modexp core (WIDTH=64, WORD=32).
module tb_rsa_word_loader;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned WORD  = 32;
  localparam int Bound = 500;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy, go, done;
  logic [WORD-1:0]  in_data, out_data;
  logic [WIDTH-1:0] message_in, exponent, modulus, cypher;

  int vec_cnt = 0;
  int err_cnt = 0;
  int go_cnt  = 0;
  int go_exp  = 0;
  logic [WORD:0] exp_q[$];

  // Core model and consumer knobs.
  int hold_cyc = 0, lat = 4, pulse = 0, rand_gap = 0, rand_rdy = 0, stall_req = 0;

  always #5 clk = ~clk;

  rsa_word_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .go(go), .message_in(message_in), .exponent(exponent), .modulus(modulus),
    .cypher(cypher), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                         input logic [63:0] m);
    logic [63:0] r = 64'd1;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // Behavioural core: done is a level (or one-cycle pulse) that may linger after a go.
  int          phase = 0, ccnt = 0;
  logic [63:0] pend;
  always @(posedge clk) begin
    if (rst) begin
      done <= 1'b0; phase <= 0; ccnt <= 0; cypher <= '0;
    end else if (go) begin
      phase <= 1; ccnt <= hold_cyc;
      pend  <= modexp(message_in, exponent, modulus);
    end else if (phase == 1) begin
      if (ccnt == 0) begin done <= 1'b0; phase <= 2; ccnt <= lat; end
      else ccnt <= ccnt - 1;
    end else if (phase == 2) begin
      if (ccnt == 0) begin
        cypher <= pend; done <= 1'b1; phase <= (pulse != 0) ? 3 : 0;
      end else ccnt <= ccnt - 1;
    end else if (phase == 3) begin
      done <= 1'b0; phase <= 0;
    end
  end

  always @(negedge clk) if (go) go_cnt++;

  // Consumer: decides out_ready for the coming edge and scores the word it will take.
  int          stall_cnt = 0;
  logic        prev_v = 1'b0, prev_r = 1'b1;
  logic [31:0] prev_d = '0;
  logic [WORD:0] e_word;
  always @(negedge clk) begin
    if (prev_v && !prev_r) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_d);
    end
    if (stall_req != 0 && out_valid && exp_q.size() == 1) begin
      stall_cnt = 5;
      stall_req = 0;
    end
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else begin
      out_ready = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_data, 64'hdead);
      end else begin
        e_word = exp_q.pop_front();
        check("out_data", out_data, e_word[31:0]);
        check("out_last", out_last, e_word[32]);
      end
    end
    prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
  end

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    if (rand_gap != 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < Bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= Bound) check("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_operands(input logic [63:0] x, input logic [63:0] e, input logic [63:0] n);
    logic [63:0] ops[3];
    ops[0] = x; ops[1] = e; ops[2] = n;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++) send_word(ops[i][k*32 +: 32]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < Bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < Bound) ? 1 : 0, 1);
    check("busy_after", busy, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  task automatic run_job(input logic [63:0] x, input logic [63:0] e, input logic [63:0] n,
                         input logic [63:0] r, input int junk);
    exp_q.push_back({1'b0, r[31:0]});
    exp_q.push_back({1'b1, r[63:32]});
    send_operands(x, e, n);
    go_exp++;
    check("op_x", message_in, x);
    check("op_e", exponent, e);
    check("op_n", modulus, n);
    if (junk != 0) begin
      in_valid = 1'b1;
      in_data  = 32'hbad0_f00d;
      repeat (12) begin
        @(negedge clk);
        check("junk_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      check("junk_op_x", message_in, x);
      check("junk_op_e", exponent, e);
      check("junk_op_n", modulus, n);
    end
    wait_idle();
    check("go_count", go_cnt, go_exp);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_go", go, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_op_x", message_in, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_go", go, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_operands", message_in | exponent | modulus, 0);

    // Basic encrypt, then decrypt round trips with a pulsed done.
    run_job(64'd8, 64'd13, 64'd77, 64'd50, 0);
    pulse = 1;
    run_job(64'd50, 64'd37, 64'd77, 64'd8, 0);
    run_job(64'd25, 64'd7, 64'd143, 64'd64, 0);
    run_job(64'd64, 64'd103, 64'd143, 64'd25, 0);

    // Backpressure on both sides; done left high afterwards.
    pulse = 0; rand_gap = 1; rand_rdy = 1; stall_req = 1;
    run_job(64'd8, 64'd13, 64'd77, 64'd50, 0);
    rand_gap = 0; rand_rdy = 0;
    check("stall_taken", stall_req, 0);

    // Stale done (old cypher 50 still visible) must not be captured.
    hold_cyc = 8;
    run_job(64'd50, 64'd37, 64'd77, 64'd8, 0);
    hold_cyc = 0;

    // Reset mid-WAIT.
    lat = 40;
    send_operands(64'd8, 64'd13, 64'd77);
    go_exp++;
    repeat (10) @(negedge clk);
    pulse_reset();
    // Reset mid-LOAD_E.
    lat = 4;
    send_word(32'd8); send_word(32'd0); send_word(32'd13);
    pulse_reset();
    run_job(64'd8, 64'd13, 64'd77, 64'd50, 0);

    // Junk on the input while the core is running.
    lat = 20;
    run_job(64'd25, 64'd7, 64'd143, 64'd64, 1);
    lat = 4;
    run_job(64'd64, 64'd103, 64'd143, 64'd25, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", err_cnt);
    $fatal(1);
  end

endmodule
